ahfp_cordic_post: RTL and testbench

Output stage directly downstream of the floating-point CORDIC rotator. Carries a 2-bit quadrant tag alongside each angle through a latency-matched pipeline, applies the quadrant correction to the rotator's IEEE-754 single cos/sin results, and buffers the corrected pairs in a small FIFO. The FIFO has a valid/ready output and a credit-based `in_ready`, so the free-running rotator never needs to stall.

---
 rtl/ahfp_cordic_post.sv | 163 ++++++++++++++++
 tb/tb_ahfp_cordic_post.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_cordic_post.sv
// rtl/ahfp_cordic_post.sv - quadrant correction and credit-controlled output FIFO behind the fp32 CORDIC rotator
//
// Carries a {valid, quad} tag through a LAT-stage pipeline that never stalls,
// so each tag lines up with the rotator result for its angle. When the last
// tag is valid, the cos/sin pair is rotated by the tagged quadrant using sign
// flips and swaps only. Zero and denormal operands become +0. The corrected
// pair is then pushed into a DEPTH-entry FIFO.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   angle enters the rotator this cycle
//   in_quad    quadrant tag: 0 none, 1 +pi/2, 2 pi, 3 -pi/2
//   x_cos      rotator cos result (fp32), valid LAT cycles after issue
//   y_sin      rotator sin result (fp32), valid LAT cycles after issue
//   in_ready   a credit is free; upstream should issue only while high
//   out_valid  FIFO head valid
//   out_ready  consumer accepts head
//   out_cos    corrected cos (fp32) at FIFO head
//   out_sin    corrected sin (fp32) at FIFO head
//   overflow   sticky; a corrected pair was dropped because the FIFO was full
module ahfp_cordic_post #(
    parameter int LAT   = 10,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  in_quad,
    input  logic [31:0] x_cos,
    input  logic [31:0] y_sin,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_cos,
    output logic [31:0] out_sin,
    output logic        overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);

    logic [LAT-1:0] tag_v;
    logic [1:0]     tag_q [LAT];

    logic           last_v;
    logic [1:0]     last_q;
    logic [31:0]    cor_c;
    logic [31:0]    cor_s;

    logic [63:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IW-1:0]  inflight;

    logic           push;
    logic           pop;

    assign last_v = tag_v[LAT-1];
    assign last_q = tag_q[LAT-1];

    // Only the valid bits need reset; stale quad values are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= in_quad;
        for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    // Quadrant rotation by swap plus sign-bit toggles, then flush exponent-0
    // operands (zero of either sign, denormals) to +0.
    always_comb begin
        cor_c = x_cos;
        cor_s = y_sin;
        case (last_q)
            2'd1: begin
                cor_c = y_sin ^ 32'h8000_0000;
                cor_s = x_cos;
            end
            2'd2: begin
                cor_c = x_cos ^ 32'h8000_0000;
                cor_s = y_sin ^ 32'h8000_0000;
            end
            2'd3: begin
                cor_c = y_sin;
                cor_s = x_cos ^ 32'h8000_0000;
            end
            default: begin
                cor_c = x_cos;
                cor_s = y_sin;
            end
        endcase
        if (cor_c[30:23] == 8'd0) begin
            cor_c = 32'h0000_0000;
        end
        if (cor_s[30:23] == 8'd0) begin
            cor_s = 32'h0000_0000;
        end
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign push      = last_v & ((count != CW'(DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cor_c, cor_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({in_valid, last_v})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
            if (last_v && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Credits cover both queued entries and results still inside the rotator.
    assign in_ready = (int'(count) + int'(inflight)) < DEPTH;

    // Head is gated by out_valid so the outputs read zero after reset
    // without clearing the storage array.
    assign out_cos = out_valid ? mem[rd_ptr][63:32] : 32'h0000_0000;
    assign out_sin = out_valid ? mem[rd_ptr][31:0]  : 32'h0000_0000;

endmodule

// File: tb/tb_ahfp_cordic_post.sv
// tb/tb_ahfp_cordic_post.sv - scoreboard bench for ahfp_cordic_post with a delay-line rotator model
module tb_ahfp_cordic_post;

    localparam int LAT   = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_quad = 2'd0;
    logic [31:0] x_cos;
    logic [31:0] y_sin;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_cos;
    logic [31:0] out_sin;
    logic        overflow;

    ahfp_cordic_post #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_quad   (in_quad),
        .x_cos     (x_cos),
        .y_sin     (y_sin),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Rotator model: a free-running delay line. Cycles without an issue carry
    // random junk, which the DUT must ignore.
    logic [31:0] cur_c = 32'h0;
    logic [31:0] cur_s = 32'h0;
    logic [31:0] rot_c [LAT];
    logic [31:0] rot_s [LAT];
    always @(posedge clk) begin
        rot_c[0] <= in_valid ? cur_c : $urandom;
        rot_s[0] <= in_valid ? cur_s : $urandom;
        for (int i = 1; i < LAT; i++) begin
            rot_c[i] <= rot_c[i-1];
            rot_s[i] <= rot_s[i-1];
        end
    end
    assign x_cos = rot_c[LAT-1];
    assign y_sin = rot_s[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] flush0(input logic [31:0] v);
        return (v[30:23] == 8'd0) ? 32'h0 : v;
    endfunction

    function automatic logic [31:0] neg(input logic [31:0] v);
        return v ^ 32'h8000_0000;
    endfunction

    // Rotation of the point (c, s) by quad * 90 degrees.
    function automatic logic [63:0] ref_pair(input logic [1:0] q, input logic [31:0] c, input logic [31:0] s);
        logic [31:0] rc, rs;
        case (q)
            2'd0: begin rc = c;      rs = s;      end
            2'd1: begin rc = neg(s); rs = c;      end
            2'd2: begin rc = neg(c); rs = neg(s); end
            default: begin rc = s;   rs = neg(c); end
        endcase
        return {flush0(rc), flush0(rs)};
    endfunction

    typedef struct {
        int          arrive;
        logic [63:0] pair;
    } pend_t;

    pend_t       pend_q [$];
    logic [63:0] mq [$];
    bit          m_ovf = 0;

    // Drive one cycle of stimulus; on an issue, record the expected pair and
    // the cycle in which the rotator result reaches the correction stage.
    task automatic step_x(input bit v, input logic [1:0] q, input logic [31:0] c, input logic [31:0] s,
                          input bit rdy, input logic [63:0] exp);
        pend_t e;
        in_valid  = v;
        in_quad   = q;
        cur_c     = c;
        cur_s     = s;
        out_ready = rdy;
        if (v) begin
            e.arrive = cyc + LAT;
            e.pair   = exp;
            pend_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input logic [1:0] q, input logic [31:0] c, input logic [31:0] s, input bit rdy);
        step_x(v, q, c, s, rdy, ref_pair(q, c, s));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 2'd0, 32'h0, 32'h0, rdy);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v[30:23] = 8'd0;
        return v;
    endfunction

    // Monitor: at the falling edge compare against the queue model, then
    // advance the model through the coming rising edge.
    always @(negedge clk) begin
        int    infl;
        bit    pop;
        pend_t e;
        if (!rst_n) begin
            mq.delete();
            pend_q.delete();
            m_ovf = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_cos",   64'(out_cos),   64'd0);
            chk("rst_out_sin",   64'(out_sin),   64'd0);
            chk("rst_in_ready",  64'(in_ready),  64'd1);
            chk("rst_overflow",  64'(overflow),  64'd0);
        end else begin
            infl = 0;
            foreach (pend_q[i]) if (pend_q[i].arrive < cyc + LAT) infl++;
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_cos", 64'(out_cos), 64'(mq[0][63:32]));
                chk("out_sin", 64'(out_sin), 64'(mq[0][31:0]));
            end
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("in_ready", 64'(in_ready), 64'((mq.size() + infl) < DEPTH));
            pop = (mq.size() != 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (pend_q.size() != 0 && pend_q[0].arrive == cyc) begin
                e = pend_q.pop_front();
                if (mq.size() < DEPTH) mq.push_back(e.pair);
                else m_ovf = 1;
            end
        end
    end

    initial begin
        int issued;
        logic [1:0] qq;
        logic [31:0] c, s;

        rst_n = 1'b0;
        idle(3, 1'b1);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Quadrant mapping with literal expectations
        step_x(1, 2'd0, 32'h3F5DB3D7, 32'h3F000000, 1, {32'h3F5DB3D7, 32'h3F000000});
        idle(2, 1);
        step_x(1, 2'd1, 32'h3F5DB3D7, 32'h3F000000, 1, {32'hBF000000, 32'h3F5DB3D7});
        idle(2, 1);
        step_x(1, 2'd2, 32'h3F5DB3D7, 32'h3F000000, 1, {32'hBF5DB3D7, 32'hBF000000});
        idle(2, 1);
        step_x(1, 2'd3, 32'h3F5DB3D7, 32'h3F000000, 1, {32'h3F000000, 32'hBF5DB3D7});
        // Zero and denormal flushing
        step_x(1, 2'd2, 32'h3F5DB3D7, 32'h00000000, 1, {32'hBF5DB3D7, 32'h00000000});
        step_x(1, 2'd0, 32'h3F5DB3D7, 32'h00000001, 1, {32'h3F5DB3D7, 32'h00000000});
        idle(LAT + 4, 1);

        // Credit exhaustion with the consumer stalled
        for (int i = 0; i < 4; i++) step(1, 2'(i), rnd_fp(), rnd_fp(), 0);
        chk("credit_after_4", 64'(in_ready), 64'd0);
        idle(LAT + 3, 0);
        step(0, 0, 0, 0, 1);
        chk("credit_after_pop", 64'(in_ready), 64'd1);
        idle(2, 0);
        idle(8, 1);

        // Streaming with random backpressure, issuing only on credit
        issued = 0;
        for (int k = 0; k < 2000 && issued < 32; k++) begin
            if (in_ready) begin
                qq = 2'($urandom_range(0, 3));
                c  = rnd_fp();
                s  = rnd_fp();
                step(1, qq, c, s, 1'($urandom_range(0, 1)));
                issued++;
            end else begin
                step(0, 0, 0, 0, 1'($urandom_range(0, 1)));
            end
        end
        chk("stream_issued", 64'(issued), 64'd32);
        idle(LAT + 10, 1);
        chk("stream_no_overflow", 64'(overflow), 64'd0);

        // Forced overflow, then push and pop together while full
        for (int i = 0; i < 5; i++) step(1, 2'($urandom_range(0, 3)), rnd_fp(), rnd_fp(), 0);
        idle(LAT + 2, 0);
        chk("ovf_set", 64'(overflow), 64'd1);
        step(1, 2'd1, rnd_fp(), rnd_fp(), 0);
        idle(LAT - 1, 0);
        step(0, 0, 0, 0, 1);
        idle(2, 0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("full_after_swap", 64'(in_ready), 64'd0);
        idle(8, 1);

        // Reset with 2 queued and 3 in flight
        step(1, 2'd0, rnd_fp(), rnd_fp(), 0);
        step(1, 2'd2, rnd_fp(), rnd_fp(), 0);
        idle(LAT, 0);
        for (int i = 0; i < 3; i++) step(1, 2'(i + 1), rnd_fp(), rnd_fp(), 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_cos",   64'(out_cos),   64'd0);
        chk("async_rst_out_sin",   64'(out_sin),   64'd0);
        chk("async_rst_in_ready",  64'(in_ready),  64'd1);
        chk("async_rst_overflow",  64'(overflow),  64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(22, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
